// File: rtl/imm_decode_pkg.sv
// rtl/imm_decode_pkg.sv - shared widths, im_op selector codes and opcodes for the immediate decode stage
package imm_decode_pkg;

  localparam int DATA_BUS    = 16;
  localparam int IM_OP_BUS   = 3;
  localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

  typedef enum logic [IM_OP_BUS-1:0] {
    IM_OP_NOP      = 3'd0,
    IM_OP_S_E_3_0  = 3'd1,
    IM_OP_S_E_4_0  = 3'd2,
    IM_OP_S_E_7_0  = 3'd3,
    IM_OP_S_E_10_0 = 3'd4,
    IM_OP_Z_E_7_0  = 3'd5
  } im_op_e;

  localparam logic [4:0] OP_ADDSP3 = 5'b00000;
  localparam logic [4:0] OP_NOP    = 5'b00001;
  localparam logic [4:0] OP_B      = 5'b00010;
  localparam logic [4:0] OP_BEQZ   = 5'b00100;
  localparam logic [4:0] OP_BNEZ   = 5'b00101;
  localparam logic [4:0] OP_SHIFT  = 5'b00110;
  localparam logic [4:0] OP_ADDIU3 = 5'b01000;
  localparam logic [4:0] OP_ADDIU  = 5'b01001;
  localparam logic [4:0] OP_GRP_SP = 5'b01100;
  localparam logic [4:0] OP_LI     = 5'b01101;
  localparam logic [4:0] OP_CMPI   = 5'b01110;
  localparam logic [4:0] OP_LW_SP  = 5'b10010;
  localparam logic [4:0] OP_LW     = 5'b10011;
  localparam logic [4:0] OP_SW_SP  = 5'b11010;
  localparam logic [4:0] OP_SW     = 5'b11011;

endpackage

// File: rtl/imm_ext.sv
// rtl/imm_ext.sv - combinational sign/zero extenders for every immediate field of an instruction
module imm_ext
  import imm_decode_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS
) (
  input  logic [15:0]           instr,
  output logic [DATA_WIDTH-1:0] s_e3_0,
  output logic [DATA_WIDTH-1:0] s_e4_0,
  output logic [DATA_WIDTH-1:0] s_e7_0,
  output logic [DATA_WIDTH-1:0] s_e10_0,
  output logic [DATA_WIDTH-1:0] z_e7_0
);

  assign s_e3_0  = {{(DATA_WIDTH-4){instr[3]}},   instr[3:0]};
  assign s_e4_0  = {{(DATA_WIDTH-5){instr[4]}},   instr[4:0]};
  assign s_e7_0  = {{(DATA_WIDTH-8){instr[7]}},   instr[7:0]};
  assign s_e10_0 = {{(DATA_WIDTH-11){instr[10]}}, instr[10:0]};
  assign z_e7_0  = {{(DATA_WIDTH-8){1'b0}},       instr[7:0]};

endmodule

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - classifies the opcode into an im_op selector and registers all immediates into ID/EX
module imm_decode
  import imm_decode_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_BUS,
  parameter int IM_OP_WIDTH = IM_OP_BUS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            instr,
  input  logic                   instr_valid,
  input  logic                   stall,
  input  logic                   flush,
  output logic [DATA_WIDTH-1:0]  im_s_e3_0,
  output logic [DATA_WIDTH-1:0]  im_s_e4_0,
  output logic [DATA_WIDTH-1:0]  im_s_e7_0,
  output logic [DATA_WIDTH-1:0]  im_s_e10_0,
  output logic [DATA_WIDTH-1:0]  im_z_e7_0,
  output logic [IM_OP_WIDTH-1:0] im_op,
  output logic                   im_valid
);

  logic [DATA_WIDTH-1:0]  s_e3_0, s_e4_0, s_e7_0, s_e10_0, z_e7_0;
  logic [IM_OP_WIDTH-1:0] im_op_d;
  logic [4:0]             op;

  assign op = instr[15:11];

  imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
    .instr   (instr),
    .s_e3_0  (s_e3_0),
    .s_e4_0  (s_e4_0),
    .s_e7_0  (s_e7_0),
    .s_e10_0 (s_e10_0),
    .z_e7_0  (z_e7_0)
  );

  always_comb begin
    im_op_d = IM_OP_NOP;
    case (op)
      OP_ADDIU3:            im_op_d = IM_OP_S_E_3_0;
      OP_LW, OP_SW:         im_op_d = IM_OP_S_E_4_0;
      OP_ADDIU, OP_ADDSP3, OP_GRP_SP, OP_BEQZ, OP_BNEZ,
      OP_CMPI, OP_LW_SP, OP_SW_SP:
                            im_op_d = IM_OP_S_E_7_0;
      OP_B:                 im_op_d = IM_OP_S_E_10_0;
      OP_LI:                im_op_d = IM_OP_Z_E_7_0;
      default:              im_op_d = IM_OP_NOP;
    endcase
  end

  // flush wins over stall so a squashed instruction can never be held in EX
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !instr_valid)) begin
      im_s_e3_0  <= '0;
      im_s_e4_0  <= '0;
      im_s_e7_0  <= '0;
      im_s_e10_0 <= '0;
      im_z_e7_0  <= '0;
      im_op      <= IM_OP_NOP;
      im_valid   <= 1'b0;
    end else if (!stall) begin
      im_s_e3_0  <= s_e3_0;
      im_s_e4_0  <= s_e4_0;
      im_s_e7_0  <= s_e7_0;
      im_s_e10_0 <= s_e10_0;
      im_z_e7_0  <= z_e7_0;
      im_op      <= im_op_d;
      im_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_decode.sv
// tb/tb_imm_decode.sv - table-driven and randomized scoreboard bench for imm_decode
module tb_imm_decode;

  typedef struct packed {
    logic [15:0] s3;
    logic [15:0] s4;
    logic [15:0] s7;
    logic [15:0] s10;
    logic [15:0] z7;
    logic [2:0]  op;
    logic        v;
  } out_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        stall;
    logic        valid;
    logic [15:0] instr;
    logic [2:0]  e_op;
    logic        e_v;
    int          sel;
    logic [15:0] e_imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, stall, instr_valid;
  logic [15:0] instr;
  logic [15:0] im_s_e3_0, im_s_e4_0, im_s_e7_0, im_s_e10_0, im_z_e7_0;
  logic [2:0]  im_op;
  logic        im_valid;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t sb_q[$];
  out_t model_q;
  vec_t vecs[$];

  always #5 clk = ~clk;

  imm_decode dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush),
    .im_s_e3_0(im_s_e3_0), .im_s_e4_0(im_s_e4_0), .im_s_e7_0(im_s_e7_0),
    .im_s_e10_0(im_s_e10_0), .im_z_e7_0(im_z_e7_0),
    .im_op(im_op), .im_valid(im_valid)
  );

  function automatic out_t decode(input logic [15:0] i);
    out_t o;
    o.s3  = 16'($signed({i[3:0], 12'h000}) >>> 12);
    o.s4  = 16'($signed({i[4:0], 11'h000}) >>> 11);
    o.s7  = 16'($signed({i[7:0], 8'h00}) >>> 8);
    o.s10 = 16'($signed({i[10:0], 5'h00}) >>> 5);
    o.z7  = {8'h00, i[7:0]};
    o.v   = 1'b1;
    case (i[15:11])
      5'b01000:                          o.op = 3'd1;
      5'b10011, 5'b11011:                o.op = 3'd2;
      5'b01001, 5'b00000, 5'b01100, 5'b00100,
      5'b00101, 5'b01110, 5'b10010, 5'b11010: o.op = 3'd3;
      5'b00010:                          o.op = 3'd4;
      5'b01101:                          o.op = 3'd5;
      default:                           o.op = 3'd0;
    endcase
    return o;
  endfunction

  function automatic out_t next_model(input out_t cur, input logic r, input logic f,
                                      input logic s, input logic v, input logic [15:0] i);
    if (r || f) return '0;
    if (s)      return cur;
    if (!v)     return '0;
    return decode(i);
  endfunction

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      1: return im_s_e3_0;
      2: return im_s_e4_0;
      3: return im_s_e7_0;
      4: return im_s_e10_0;
      default: return im_z_e7_0;
    endcase
  endfunction

  task automatic step(input logic r, input logic f, input logic s, input logic v,
                      input logic [15:0] i);
    out_t exp, got;
    @(negedge clk);
    rst = r; flush = f; stall = s; instr_valid = v; instr = i;
    model_q = next_model(model_q, r, f, s, v, i);
    sb_q.push_back(model_q);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    got = {im_s_e3_0, im_s_e4_0, im_s_e7_0, im_s_e10_0, im_z_e7_0, im_op, im_valid};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL scoreboard instr=%h got=%h expected=%h", i, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic s, input logic v,
                     input logic [15:0] i, input logic [2:0] eo, input logic ev,
                     input int sel, input logic [15:0] ei);
    vec_t t;
    t.rst = r; t.flush = f; t.stall = s; t.valid = v; t.instr = i;
    t.e_op = eo; t.e_v = ev; t.sel = sel; t.e_imm = ei;
    vecs.push_back(t);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    model_q = '0;

    add(1, 0, 0, 0, 16'h0000, 3'd0, 0, 3, 16'h0000);  // reset
    add(1, 0, 0, 1, 16'h6AFF, 3'd0, 0, 5, 16'h0000);
    add(0, 0, 0, 1, 16'h6AFF, 3'd5, 1, 5, 16'h00FF);  // LI
    add(0, 0, 0, 1, 16'h4108, 3'd1, 1, 1, 16'hFFF8);  // ADDIU3
    add(0, 0, 0, 1, 16'h9A3F, 3'd2, 1, 2, 16'hFFFF);  // LW
    add(0, 0, 0, 1, 16'h1400, 3'd4, 1, 4, 16'hFC00);  // B
    add(0, 0, 0, 1, 16'h4980, 3'd3, 1, 3, 16'hFF80);  // ADDIU
    add(0, 0, 1, 1, 16'h6AFF, 3'd3, 1, 3, 16'hFF80);  // stall x3
    add(0, 0, 1, 1, 16'h6AFF, 3'd3, 1, 3, 16'hFF80);
    add(0, 0, 1, 0, 16'h6AFF, 3'd3, 1, 3, 16'hFF80);
    add(0, 0, 0, 1, 16'h6AFF, 3'd5, 1, 3, 16'hFFFF);  // stalled LI now enters
    add(0, 1, 1, 1, 16'h6AFF, 3'd0, 0, 5, 16'h0000);  // flush + stall
    add(0, 0, 0, 1, 16'hE000, 3'd0, 1, 1, 16'h0000);  // R-type
    add(0, 0, 0, 1, 16'h1400, 3'd4, 1, 4, 16'hFC00);
    add(0, 0, 1, 1, 16'h1400, 3'd4, 1, 4, 16'hFC00);
    add(1, 0, 1, 1, 16'h1400, 3'd0, 0, 4, 16'h0000);  // reset during stall
    add(0, 0, 0, 0, 16'h1400, 3'd0, 0, 4, 16'h0000);
    add(0, 0, 0, 1, 16'h1400, 3'd4, 1, 4, 16'hFC00);
    add(0, 1, 0, 1, 16'h4980, 3'd0, 0, 3, 16'h0000);  // flush alone
    add(0, 0, 0, 1, 16'h0800, 3'd0, 1, 2, 16'h0000);  // NOP opcode
    add(0, 0, 0, 1, 16'h3000, 3'd0, 1, 3, 16'h0000);  // shift group
    add(0, 0, 0, 1, 16'hD87F, 3'd2, 1, 2, 16'hFFFF);  // SW

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].flush, vecs[k].stall, vecs[k].valid, vecs[k].instr);
      n_checks++;
      if (im_op !== vecs[k].e_op || im_valid !== vecs[k].e_v ||
          pick(vecs[k].sel) !== vecs[k].e_imm) begin
        n_fail++;
        $display("FAIL vec%0d got op=%0d v=%0b imm=%h expected op=%0d v=%0b imm=%h",
                 k, im_op, im_valid, pick(vecs[k].sel), vecs[k].e_op, vecs[k].e_v,
                 vecs[k].e_imm);
      end
    end

    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
